// File: rtl/hier_pipe_combine_pkg.sv
// Shared types and helpers for the hier_pipe_combine datapath.
// Defines the combine-mode encoding, the pipeline depth ceiling and
// a parity helper used when HIER_PIPE_COMBINE_PARITY_EN is defined.
package hier_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_XOR  = 2'b01,
        MODE_OR   = 2'b10,
        MODE_HIST = 2'b11
    } mode_e;

    localparam int DEPTH_MAX = 8;

    // Even parity of a channel value; callers zero-extend to 32 bits.
    function automatic logic even_parity(input logic [31:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/hier_pipe_stage.sv
// One valid/ready register slice of the hier_pipe_combine pipeline.
// The slice loads whenever it is empty or its content leaves this cycle,
// so ready ripples combinationally from the sink back to the source.
module hier_pipe_stage #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    logic          valid_r;
    logic [DW-1:0] data_r;

    assign in_ready  = !valid_r || out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Slice register: take a new beat (or a bubble) when free, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {DW{1'b0}};
        end else if (in_ready) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end else begin
                data_r <= data_r;
            end
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

endmodule

// File: rtl/hier_pipe_combine.sv
// hier_pipe_combine: per-channel combine of two operand vectors followed
// by a DEPTH-stage valid/ready pipeline and a saturating output counter.
// Optional feature macro: HIER_PIPE_COMBINE_PARITY_EN adds out_parity,
// computed at the first stage and carried alongside the data.
module hier_pipe_combine
    import hier_pipe_pkg::*;
#(
    parameter int W     = 4,
    parameter int CH    = 3,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH*W-1:0]   in_a,
    input  logic [CH*W-1:0]   in_b,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH*W-1:0]   out_data,
    output logic [CNT_W-1:0]  txn_count
`ifdef HIER_PIPE_COMBINE_PARITY_EN
    ,
    output logic [CH-1:0]     out_parity
`endif
);

    localparam int STAGES = (DEPTH < 1) ? 1 : ((DEPTH > DEPTH_MAX) ? DEPTH_MAX : DEPTH);
    localparam int RW     = CH * W;
`ifdef HIER_PIPE_COMBINE_PARITY_EN
    localparam int DW     = RW + CH;
`else
    localparam int DW     = RW;
`endif

    logic             accept_s;
    logic [RW-1:0]    comb_s;
    logic [DW-1:0]    stage1_s;
    logic [CNT_W-1:0] txn_r;
`ifdef HIER_PIPE_COMBINE_PARITY_EN
    logic [CH-1:0]    par_s;
`endif

    assign accept_s = in_valid && in_ready;

    genvar k;
    generate
        for (k = 0; k < CH; k++) begin : g_chan
            logic [W-1:0] a_s;
            logic [W-1:0] b_s;
            logic [W-1:0] res_s;
            logic [W-1:0] hist_r;

            assign a_s = in_a[k*W +: W];
            assign b_s = in_b[k*W +: W];

            // History tracks operand A of every accepted beat, whatever the mode.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hist_r <= {W{1'b0}};
                end else if (accept_s) begin
                    hist_r <= a_s;
                end else begin
                    hist_r <= hist_r;
                end
            end

            // Channel combine; HIST sees the history value from before this beat.
            always_comb begin
                res_s = {W{1'b0}};
                case (mode_e'(mode))
                    MODE_ADD:  res_s = a_s + b_s;
                    MODE_XOR:  res_s = a_s ^ b_s;
                    MODE_OR:   res_s = a_s | b_s;
                    MODE_HIST: res_s = hist_r | (a_s ^ b_s);
                    default:   res_s = {W{1'b0}};
                endcase
            end

            assign comb_s[k*W +: W] = res_s;
`ifdef HIER_PIPE_COMBINE_PARITY_EN
            assign par_s[k] = even_parity(32'(res_s));
`endif
        end
    endgenerate

`ifdef HIER_PIPE_COMBINE_PARITY_EN
    assign stage1_s = {par_s, comb_s};
`else
    assign stage1_s = comb_s;
`endif

    genvar i;
    generate
        for (i = 0; i < STAGES; i++) begin : g_stage
            logic          v_s;
            logic [DW-1:0] d_s;
            logic          rdy_s;
            logic          up_v_s;
            logic [DW-1:0] up_d_s;
            logic          dn_rdy_s;

            if (i == 0) begin : g_head
                assign up_v_s = in_valid;
                assign up_d_s = stage1_s;
            end else begin : g_link
                assign up_v_s = g_stage[i-1].v_s;
                assign up_d_s = g_stage[i-1].d_s;
            end

            if (i == STAGES - 1) begin : g_tail
                assign dn_rdy_s = out_ready;
            end else begin : g_mid
                assign dn_rdy_s = g_stage[i+1].rdy_s;
            end

            hier_pipe_stage #(
                .DW (DW)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (up_v_s),
                .in_data   (up_d_s),
                .in_ready  (rdy_s),
                .out_valid (v_s),
                .out_data  (d_s),
                .out_ready (dn_rdy_s)
            );
        end
    endgenerate

    assign in_ready   = g_stage[0].rdy_s;
    assign out_valid  = g_stage[STAGES-1].v_s;
    assign out_data   = g_stage[STAGES-1].d_s[RW-1:0];
`ifdef HIER_PIPE_COMBINE_PARITY_EN
    assign out_parity = g_stage[STAGES-1].d_s[DW-1:RW];
`endif

    // Count drained beats, pinned at the all-ones value instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_r <= {CNT_W{1'b0}};
        end else if (out_valid && out_ready && (txn_r != {CNT_W{1'b1}})) begin
            txn_r <= txn_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            txn_r <= txn_r;
        end
    end

    assign txn_count = txn_r;

endmodule

// File: tb/tb_hier_pipe_combine.sv
// Scoreboard bench for hier_pipe_combine: the driver pushes the expected
// result of each accepted beat; a monitor pops and compares on every
// output handshake and also checks hold-under-stall and the counter.
module tb_hier_pipe_combine;

    localparam int W     = 4;
    localparam int CH    = 3;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;
    localparam int RW    = CH * W;
    localparam int MAXC  = (1 << CNT_W) - 1;

    typedef struct {
        logic [RW-1:0] data;
        logic [CH-1:0] par;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [RW-1:0]    in_a;
    logic [RW-1:0]    in_b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    out_data;
    logic [CNT_W-1:0] txn_count;
`ifdef HIER_PIPE_COMBINE_PARITY_EN
    logic [CH-1:0]    out_parity;
`endif

    hier_pipe_combine #(
        .W     (W),
        .CH    (CH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .txn_count  (txn_count)
`ifdef HIER_PIPE_COMBINE_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            vectors     = 0;
    int            miscompares = 0;
    exp_t          exp_q[$];
    logic [W-1:0]  hist[CH];
    int            exp_txn     = 0;
    bit            prev_stall  = 1'b0;
    logic [RW-1:0] prev_data;
    logic [CH-1:0] prev_par;
    bit            rand_ready  = 1'b0;
    int            stall_cycles = 0;
    exp_t          got;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: apply the per-channel rules to one accepted beat.
    task automatic model_push(input logic [RW-1:0] a, input logic [RW-1:0] b, input logic [1:0] m);
        exp_t         e;
        logic [W-1:0] ak;
        logic [W-1:0] bk;
        logic [W-1:0] r;
        e.data = '0;
        e.par  = '0;
        for (int c = 0; c < CH; c++) begin
            ak = a[c*W +: W];
            bk = b[c*W +: W];
            case (m)
                2'd0:    r = W'((int'(ak) + int'(bk)) % (1 << W));
                2'd1:    r = ak ^ bk;
                2'd2:    r = ak | bk;
                default: r = hist[c] | (ak ^ bk);
            endcase
            hist[c] = ak;
            e.data[c*W +: W] = r;
            e.par[c] = ^r;
        end
        exp_q.push_back(e);
    endtask

    // Offer one beat until accepted; inputs change 2 units after negedge.
    task automatic send(input logic [RW-1:0] a, input logic [RW-1:0] b, input logic [1:0] m);
        int waited = 0;
        bit done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            #2;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            in_a     = a;
            in_b     = b;
            mode     = m;
            #1;
            if (in_ready) begin
                model_push(a, b, m);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 100) begin
                    check("send_timeout", 64'd1, 64'd0);
                    done = 1'b1;
                end
            end
        end
        stall_cycles += waited;
    endtask

    task automatic send_rand();
        send(RW'($urandom), RW'($urandom), 2'($urandom_range(0, 3)));
    endtask

    task automatic idle();
        @(negedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #6;
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < CH; c++) hist[c] = '0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_txn_count", 64'(txn_count), 64'd0);
`ifdef HIER_PIPE_COMBINE_PARITY_EN
        check("rst_out_parity", 64'(out_parity), 64'd0);
`endif
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    // Monitor: sample just before each rising edge and score handshakes.
    always begin
        @(negedge clk);
        #4;
        if (!rst_n) begin
            exp_q.delete();
            exp_txn    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", 64'(out_valid), 64'd1);
                check("stall_hold_data", 64'(out_data), 64'(prev_data));
`ifdef HIER_PIPE_COMBINE_PARITY_EN
                check("stall_hold_parity", 64'(out_parity), 64'(prev_par));
`endif
            end
            if (out_valid && out_ready) begin
                check("txn_count", 64'(txn_count), 64'(exp_txn));
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    got = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(got.data));
`ifdef HIER_PIPE_COMBINE_PARITY_EN
                    check("out_parity", 64'(out_parity), 64'(got.par));
`endif
                end
                if (exp_txn < MAXC) exp_txn++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
`ifdef HIER_PIPE_COMBINE_PARITY_EN
            prev_par   = out_parity;
`else
            prev_par   = '0;
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        mode      = 2'd0;
        out_ready = 1'b1;
        for (int c = 0; c < CH; c++) hist[c] = '0;
        do_reset();

        // Single ADD beat: carry dropped in the top channel, latency = DEPTH.
        send(12'hF13, 12'h114, 2'd0);
        idle();
        #2;
        check("lat_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        #4;
        check("lat_exact", 64'(out_valid), 64'd1);
        check("t1_data", 64'(out_data), 64'h027);
        @(negedge clk);
        #4;
        check("t1_txn", 64'(txn_count), 64'd1);

        // HIST uses the previous beat's operand A.
        send(12'h555, 12'h000, 2'd1);
        send(12'h000, 12'h333, 2'd3);
        drain();

        // Reset with beats in flight, then HIST must see cleared history.
        @(negedge clk);
        #2;
        out_ready = 1'b0;
        send_rand();
        send_rand();
        idle();
        do_reset();
        out_ready = 1'b1;
        send(12'h000, 12'h111, 2'd3);
        drain();

        // Backpressure: only DEPTH of 5 offered beats get in.
        @(negedge clk);
        #2;
        out_ready = 1'b0;
        accepted  = 0;
        for (int j = 0; j < 5; j++) begin
            logic [RW-1:0] ra;
            logic [RW-1:0] rb;
            logic [1:0]    rm;
            if (j != 0) @(negedge clk);
            if (j != 0) #2;
            ra = RW'($urandom);
            rb = RW'($urandom);
            rm = 2'($urandom_range(0, 3));
            in_valid = 1'b1;
            in_a = ra;
            in_b = rb;
            mode = rm;
            #1;
            if (in_ready) begin
                model_push(ra, rb, rm);
                accepted++;
            end
        end
        idle();
        #1;
        check("bp_accepted", 64'(accepted), 64'(DEPTH));
        check("bp_in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clk);
        drain();

        // Full-throughput streaming of 100 random beats.
        do_reset();
        stall_cycles = 0;
        for (int j = 0; j < 100; j++) send_rand();
        drain();
        check("stream_stalls", 64'(stall_cycles), 64'd0);
        check("stream_txn", 64'(txn_count), 64'd100);

        // Random backpressure with random beats.
        rand_ready = 1'b1;
        for (int j = 0; j < 60; j++) send_rand();
        rand_ready = 1'b0;
        drain();

`ifdef HIER_PIPE_COMBINE_PARITY_EN
        // Directed parity case: each channel 0x7 has odd weight -> parity 1.
        send(12'h777, 12'h000, 2'd1);
        drain();
`endif

        // Counter saturation.
        do_reset();
        for (int j = 0; j < 300; j++) send_rand();
        drain();
        check("sat_txn", 64'(txn_count), 64'(MAXC));
        for (int j = 0; j < 5; j++) send_rand();
        drain();
        check("sat_txn_hold", 64'(txn_count), 64'(MAXC));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hier_pipe_combine.md
Name: hier_pipe_combine

Overview:
Parametrised successor to the fixed 1-bit/3-bit hierarchical combiners used as insertFF test targets. Combines two operand vectors over CH independent channels of W bits each, using one of four runtime modes. The result passes through a DEPTH-stage valid/ready pipeline. The block serves as a scalable, flop-rich test target for the FF-insertion and EQED flows, and as a reusable datapath leaf.

Parameters:
- W, 4, bits per channel
- CH, 3, number of channels
- DEPTH, 2, pipeline register stages (1..8)
- CNT_W, 8, width of the output transaction counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_a  in  CH*W  operand A; channel k is bits [k*W +: W]
- in_b  in  CH*W  operand B; same channel packing as in_a
- mode  in  2  combine mode, sampled with the beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  CH*W  per-channel result
- txn_count  out  CNT_W  accepted output beats, saturating

Behaviour:
- Reset (async assert, sync deassert by the system): all stage valids = 0; out_valid = 0; out_data = 0; txn_count = 0; per-channel history regs = 0. in_ready = 1 once reset is released.
- Input accept: a beat is accepted when in_valid && in_ready.
- Combine, per channel k, computed combinationally at accept and registered into stage 1:
  - mode 00 ADD: (a+b) mod 2^W, carry dropped.
  - mode 01 XOR: a^b.
  - mode 10 OR: a|b.
  - mode 11 HIST: hist_k | (a^b).
- History register hist_k: updated to a_k on every accepted beat, in all modes. HIST uses the value before this beat's update. The first HIST beat after reset therefore uses hist = 0.
- Pipeline: DEPTH register stages, each holding a valid bit plus CH*W data bits.
  - Stage i loads from stage i-1 when stage i is empty or stage i is advancing.
  - The last stage advances when out_ready = 1.
  - in_ready = !v[1] || stage 1 advancing. Ready propagates combinationally backward; there is no skid buffer.
- Latency: exactly DEPTH cycles from accept to out_valid when the pipeline is unstalled. Throughput is 1 beat/cycle at steady state.
- Stall: while out_valid && !out_ready, out_data and out_valid are held stable. A full pipeline deasserts in_ready.
- Bubble collapse: an empty stage accepts new data even while downstream stages are stalled.
- txn_count: increments on out_valid && out_ready. It saturates at 2^CNT_W-1 and never wraps.
- Simultaneous accept and drain on a full pipeline: both occur in the same cycle; occupancy is unchanged.
- Reset mid-operation: all in-flight beats are discarded and history is cleared. No partial output appears after reset.
- mode is a per-beat attribute. Changing mode never affects beats already in flight.

Optional Feature:
- Macro: HIER_PIPE_COMBINE_PARITY_EN.
- With the macro defined:
  - Extra output out_parity, width CH: bit k is the even parity (XOR-reduce) of channel k's result.
  - Parity is computed at stage 1 and carried through the pipeline alongside the data.
  - out_parity has the same reset value, hold and stall rules as out_data.
- Without the macro: the port and its registers are absent; all other behaviour is identical.

Decomposition:
- Shared package hier_pipe_pkg:
  - mode enum: MODE_ADD=2'b00, MODE_XOR=2'b01, MODE_OR=2'b10, MODE_HIST=2'b11.
  - constant DEPTH_MAX = 8.
- One sub-module hier_pipe_stage (params DW):
  - single valid/ready register slice with async active-low reset.
  - instantiated DEPTH times by generate.
  - data width is CH*W, or CH*W+CH with parity enabled.
- Combine logic and history registers stay in the top module, in a per-channel generate loop.

Test Plan:
- Reset then single beat, W=4, CH=3, DEPTH=2, mode ADD, a={4'hF,4'h1,4'h3}, b={4'h1,4'h1,4'h4}, out_ready=1 -> out_valid rises exactly 2 cycles after accept, out_data={4'h0,4'h2,4'h7}, txn_count=1.
- Mode HIST sequence: beat1 a=0x5,b=0x0 (XOR); beat2 HIST a=0x0,b=0x3 -> beat2 result 0x5|0x3 = 0x7 on every channel. Then assert reset and send HIST a=0,b=1 -> result 0x1.
- Backpressure: out_ready=0 while 5 beats are offered -> exactly DEPTH beats are accepted, in_ready=0 after that, out_data is stable. Releasing out_ready drains the beats in order with no loss or duplication.
- Full-throughput streaming: 100 random beats with out_ready=1 and in_valid=1 -> one output per cycle, matching the scoreboard model, txn_count=100.
- Saturation: CNT_W=3, 10 outputs -> txn_count reads 7 and stays 7.
- Parity build: HIER_PIPE_COMBINE_PARITY_EN defined, mode XOR, a=0x7,b=0x0 on all channels -> out_parity=3'b111. Stall and reset behaviour of out_parity matches out_data.
